// File: rtl/fb_arbiter_if.sv
// Framebuffer arbiter bus bundle: VGA fetch, CPU window, clear control and RAM port.
interface fb_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 4
);
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_rdata;
  logic              vga_rvalid;
  logic              cpu_valid;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic              clr_start;
  logic              clr_busy;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  vga_req, vga_addr,
    input  cpu_valid, cpu_we, cpu_addr, cpu_wdata,
    input  clr_start, mem_rdata,
    output vga_rdata, vga_rvalid,
    output cpu_ready, cpu_rdata, cpu_rvalid,
    output clr_busy,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output vga_req, vga_addr,
    output cpu_valid, cpu_we, cpu_addr, cpu_wdata,
    output clr_start, mem_rdata,
    input  vga_rdata, vga_rvalid,
    input  cpu_ready, cpu_rdata, cpu_rvalid,
    input  clr_busy,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: VGA > clear > write-buffer drain > CPU read.
// VGA reads keep a fixed 1-cycle latency; CPU stores drain into free cycles.
module fb_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 4,
  parameter int WBUF_DEPTH = 2
) (
  input logic         clk,
  input logic         reset,
  fb_arbiter_if.slave bus
);
  localparam int PW = $clog2(WBUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DRAIN,
    CLEAR
  } clr_st_t;

  clr_st_t st, st_nx;

  logic [ADDR_W:0]   clr_cnt;
  logic [ADDR_W:0]   cnt_inc;
  logic [ADDR_W-1:0] wb_addr [WBUF_DEPTH];
  logic [DATA_W-1:0] wb_data [WBUF_DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW:0]       count;

  logic full, empty, busy;
  logic vga_win, clr_step, drain;
  logic ready, push, rd_acc;
  logic vga_rv_q, cpu_rv_q;

  assign full     = count == (PW+1)'(WBUF_DEPTH);
  assign empty    = count == '0;
  assign busy     = st != IDLE;
  assign vga_win  = reset & bus.vga_req;
  assign clr_step = (st == CLEAR) & !bus.vga_req;
  assign drain    = !empty & !bus.vga_req & !clr_step;
  assign cnt_inc  = clr_cnt + 1'b1;

  // reads wait for an empty buffer so they never overtake a store
  assign ready = reset & !busy &
                 (bus.cpu_we ? !full : (empty & !bus.vga_req));
  assign push   = bus.cpu_valid & bus.cpu_we & ready;
  assign rd_acc = bus.cpu_valid & !bus.cpu_we & ready;

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (1'b1)
      vga_win: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = bus.vga_addr;
      end
      clr_step: begin
        bus.mem_en   = 1'b1;
        bus.mem_we   = 1'b1;
        bus.mem_addr = clr_cnt[ADDR_W-1:0];
      end
      drain: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = wb_addr[rd_ptr];
        bus.mem_wdata = wb_data[rd_ptr];
      end
      rd_acc: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = bus.cpu_addr;
      end
      default: ;
    endcase
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE:       if (bus.clr_start) st_nx = WAIT_DRAIN;
      WAIT_DRAIN: if (empty) st_nx = CLEAR;
      CLEAR:      if (clr_step & cnt_inc[ADDR_W]) st_nx = IDLE;
      default:    st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= IDLE;
    end else begin
      st <= st_nx;
    end
  end

  // extra counter bit flags the wrap past the last address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_cnt <= '0;
    end else if (clr_step) begin
      clr_cnt <= cnt_inc[ADDR_W] ? '0 : cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < WBUF_DEPTH; i++) begin
        wb_addr[i] <= '0;
        wb_data[i] <= '0;
      end
    end else begin
      if (push) begin
        wb_addr[wr_ptr] <= bus.cpu_addr;
        wb_data[wr_ptr] <= bus.cpu_wdata;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (drain) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vga_rv_q <= 1'b0;
      cpu_rv_q <= 1'b0;
    end else begin
      vga_rv_q <= vga_win;
      cpu_rv_q <= rd_acc;
    end
  end

  assign bus.vga_rvalid = vga_rv_q;
  assign bus.vga_rdata  = vga_rv_q ? bus.mem_rdata : '0;
  assign bus.cpu_rvalid = cpu_rv_q;
  assign bus.cpu_rdata  = cpu_rv_q ? bus.mem_rdata : '0;
  assign bus.cpu_ready  = ready;
  assign bus.clr_busy   = busy;
endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: RAM model, queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_fb_arbiter;
  localparam int AW    = 10;
  localparam int DW    = 4;
  localparam int DEPTH = 2;
  localparam int N     = 1 << AW;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  bit   preload = 1'b1;

  int tests = 0;
  int fails = 0;

  fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fb_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .WBUF_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(int i);
    return DW'((i + 4) % 15 + 1);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // framebuffer RAM, 1-cycle read latency
  logic [DW-1:0] ram [N];
  logic [DW-1:0] rdq = '0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < N; i++) ram[i] <= pat(i);
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else rdq <= ram[bus.mem_addr];
    end
  end

  assign bus.mem_rdata = rdq;

  // reference model: pending stores as a queue, clear as phase+index
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           wq[$];
  int            phase = 0;
  int            m_idx = 0;
  logic [DW-1:0] m_ram [N];
  bit            vpend = 0;
  bit            cpend = 0;
  logic [DW-1:0] vdat = '0;
  logic [DW-1:0] cdat = '0;

  always @(negedge clk) begin : model
    bit            busy, empty, full, step, drn, rdy, wacc, racc, e_en, e_we;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d;
    wr_t           w;
    if (!reset) begin
      chk("reset_outputs", 32'({bus.vga_rvalid, bus.vga_rdata,
          bus.cpu_ready, bus.cpu_rdata, bus.cpu_rvalid, bus.clr_busy,
          bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'd0);
      wq.delete();
      phase = 0;
      m_idx = 0;
      vpend = 0;
      cpend = 0;
    end else begin
      busy  = phase != 0;
      empty = wq.size() == 0;
      full  = wq.size() == DEPTH;
      step  = phase == 2 && !bus.vga_req;
      drn   = !empty && !bus.vga_req && !step;
      rdy   = !busy && (bus.cpu_we ? !full : (empty && !bus.vga_req));
      wacc  = bus.cpu_valid && bus.cpu_we && rdy;
      racc  = bus.cpu_valid && !bus.cpu_we && rdy;
      e_en  = 1; e_we = 0; e_a = '0; e_d = '0;
      if (bus.vga_req) e_a = bus.vga_addr;
      else if (step) begin e_we = 1; e_a = AW'(m_idx); end
      else if (drn) begin e_we = 1; e_a = wq[0].a; e_d = wq[0].d; end
      else if (racc) e_a = bus.cpu_addr;
      else e_en = 0;
      chk("vga_rvalid", 32'(bus.vga_rvalid), 32'(vpend));
      chk("vga_rdata", 32'(bus.vga_rdata), 32'(vpend ? vdat : '0));
      chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(cpend));
      chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(cpend ? cdat : '0));
      chk("cpu_ready", 32'(bus.cpu_ready), 32'(rdy));
      chk("clr_busy", 32'(bus.clr_busy), 32'(busy));
      chk("mem_en", 32'(bus.mem_en), 32'(e_en));
      chk("mem_we", 32'(bus.mem_we), 32'(e_we));
      if (e_en) chk("mem_addr", 32'(bus.mem_addr), 32'(e_a));
      if (e_we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_d));
      vpend = bus.vga_req;
      if (bus.vga_req) vdat = m_ram[bus.vga_addr];
      cpend = racc;
      if (racc) cdat = m_ram[bus.cpu_addr];
      if (drn) begin
        m_ram[wq[0].a] = wq[0].d;
        void'(wq.pop_front());
      end
      if (wacc) begin
        w.a = bus.cpu_addr;
        w.d = bus.cpu_wdata;
        wq.push_back(w);
      end
      case (phase)
        0: if (bus.clr_start) phase = 1;
        1: if (empty) phase = 2;
        default: if (step) begin
          m_ram[m_idx] = '0;
          m_idx++;
          if (m_idx == N) begin
            m_idx = 0;
            phase = 0;
          end
        end
      endcase
    end
    if (preload) for (int i = 0; i < N; i++) m_ram[i] = pat(i);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.vga_req   = 0;
    bus.vga_addr  = '0;
    bus.cpu_valid = 0;
    bus.cpu_we    = 0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.clr_start = 0;
  endtask

  task automatic cpu(bit we, int a, int d);
    bus.cpu_valid = 1;
    bus.cpu_we    = we;
    bus.cpu_addr  = AW'(a);
    bus.cpu_wdata = DW'(d);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, got, nz, done;
    idle();
    for (int i = 0; i < 4; i++) begin
      bus.vga_req   = 1'($urandom);
      bus.vga_addr  = AW'($urandom);
      bus.cpu_valid = 1'($urandom);
      bus.cpu_we    = 1'($urandom);
      bus.cpu_addr  = AW'($urandom);
      bus.cpu_wdata = DW'($urandom);
      bus.clr_start = 1'($urandom);
      tick();
    end
    @(negedge clk);
    chk("rst_ready_lit", 32'(bus.cpu_ready), 32'd0);
    tick();
    idle();
    preload = 0;
    reset = 1;
    tick();

    bus.vga_req = 1; bus.vga_addr = 5;
    tick();
    bus.vga_req = 0;
    @(negedge clk);
    chk("vga_lat_valid", 32'(bus.vga_rvalid), 32'd1);
    chk("vga_lat_data", 32'(bus.vga_rdata), 32'hA);
    tick();

    cpu(1, 'h21, 3);
    @(negedge clk); chk("wr0_ready", 32'(bus.cpu_ready), 32'd1);
    tick();
    cpu(1, 'h22, 7);
    @(negedge clk); chk("wr1_ready", 32'(bus.cpu_ready), 32'd1);
    tick();
    idle();
    tick();
    chk("ram21", 32'(ram['h21]), 32'h3);
    chk("ram22", 32'(ram['h22]), 32'h7);
    cpu(0, 'h22, 0);
    @(negedge clk); chk("rd_ready", 32'(bus.cpu_ready), 32'd1);
    tick();
    idle();
    @(negedge clk);
    chk("rd_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    chk("rd_rdata", 32'(bus.cpu_rdata), 32'h7);
    tick();

    acc = 0;
    for (int i = 0; i < 20; i++) begin
      bus.vga_req = 1; bus.vga_addr = AW'(100 + i);
      if (acc < 3) cpu(1, 'h40 + acc, acc + 1);
      else bus.cpu_valid = 0;
      @(negedge clk);
      if (bus.cpu_valid && bus.cpu_ready) acc++;
      tick();
    end
    chk("contention_acc", 32'(acc), 32'd2);
    @(negedge clk); chk("third_held", 32'(bus.cpu_ready), 32'd0);
    tick();
    bus.vga_req = 0;
    for (int k = 0; k < 10 && acc < 3; k++) begin
      @(negedge clk);
      if (bus.cpu_valid && bus.cpu_ready) acc++;
      tick();
    end
    chk("third_accepted", 32'(acc), 32'd3);
    idle();
    repeat (3) tick();
    chk("ram42", 32'(ram['h42]), 32'h3);

    bus.vga_req = 1; bus.vga_addr = 7;
    cpu(1, 'h50, 9);
    @(negedge clk); chk("ord_wr_ready", 32'(bus.cpu_ready), 32'd1);
    tick();
    cpu(0, 'h50, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("ord_rd_blocked", 32'(bus.cpu_ready), 32'd0);
      tick();
    end
    bus.vga_req = 0;
    got = 0;
    for (int k = 0; k < 10 && got == 0; k++) begin
      @(negedge clk);
      if (bus.cpu_ready) got = 1;
      tick();
    end
    chk("ord_rd_accept", 32'(got), 32'd1);
    idle();
    @(negedge clk);
    chk("ord_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    chk("ord_rdata", 32'(bus.cpu_rdata), 32'h9);
    tick();

    cpu(1, 'h60, 5);
    bus.clr_start = 1;
    @(negedge clk); chk("clr_wr_ready", 32'(bus.cpu_ready), 32'd1);
    tick();
    idle();
    done = 0;
    for (int c = 0; c < 4000 && done == 0; c++) begin
      bus.vga_req   = (c % 2) == 1;
      bus.vga_addr  = AW'(c);
      bus.clr_start = (c == 10);
      if (c < 5) cpu(1, 'h61, 6);
      else bus.cpu_valid = 0;
      @(negedge clk);
      if (c == 0) begin
        chk("clr_busy_set", 32'(bus.clr_busy), 32'd1);
        chk("clr_ready_low", 32'(bus.cpu_ready), 32'd0);
      end
      if (!bus.clr_busy) done = 1;
      tick();
    end
    chk("clr_done", 32'(done), 32'd1);
    idle();
    nz = 0;
    for (int i = 0; i < N; i++) if (ram[i] != '0) nz++;
    chk("ram_all_zero", 32'(nz), 32'd0);
    chk("ram60_zero", 32'(ram['h60]), 32'd0);
    repeat (3) tick();
    @(negedge clk); chk("clr_stays_idle", 32'(bus.clr_busy), 32'd0);
    tick();

    preload = 1;
    tick();
    preload = 0;
    bus.clr_start = 1;
    tick();
    bus.clr_start = 0;
    for (int k = 0; k < 2000 && m_idx != 300; k++) tick();
    chk("reach_300", 32'(m_idx), 32'd300);
    reset = 0;
    #1;
    chk("rst_busy_drop", 32'(bus.clr_busy), 32'd0);
    tick();
    tick();
    reset = 1;
    tick();
    chk("ram299_zero", 32'(ram[299]), 32'd0);
    chk("ram300_kept", 32'(ram[300]), 32'h5);
    nz = 0;
    for (int i = 300; i < N; i++) if (ram[i] != pat(i)) nz++;
    chk("upper_kept", 32'(nz), 32'd0);
    cpu(0, 300, 0);
    @(negedge clk); chk("post_rst_rd_ready", 32'(bus.cpu_ready), 32'd1);
    tick();
    idle();
    @(negedge clk);
    chk("post_rst_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    chk("post_rst_rdata", 32'(bus.cpu_rdata), 32'h5);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
